// File: rtl/cirno9_mem_pkg.sv
// Shared constants and helpers for the cirno9 SRAM controller slice.
// Arbitration modes, requester port ids and a log2 helper for parameter math.
package cirno9_mem_pkg;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  localparam logic PORT_LSU  = 1'b0;
  localparam logic PORT_IFU  = 1'b1;

  // Ceiling log2; log2_f(1) = 0, log2_f(4096) = 12.
  function automatic int log2_f(input int unsigned val);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < val) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cirno9_rr_arb2.sv
// Two-request arbiter: fixed priority (port 0 first) or round-robin via a
// last_grant register. Grant is one-hot and combinational from the requests.
module cirno9_rr_arb2
  import cirno9_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic       last_grant_r;
  logic [1:0] gnt_s;

  // On a round-robin conflict the port that did not win last time is granted.
  always_comb begin
    gnt_s = 2'b00;
    if ((mode == ARB_RR) && (req == 2'b11)) begin
      if (last_grant_r == PORT_IFU) begin
        gnt_s = 2'b01;
      end else begin
        gnt_s = 2'b10;
      end
    end else if (req[0]) begin
      gnt_s = 2'b01;
    end else if (req[1]) begin
      gnt_s = 2'b10;
    end else begin
      gnt_s = 2'b00;
    end
  end

  // last_grant only moves on an actual grant; reset to 1 so port 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (gnt_s[1]) begin
      last_grant_r <= PORT_IFU;
    end else if (gnt_s[0]) begin
      last_grant_r <= PORT_LSU;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/cirno9_sram_ctrl.sv
// Single-bank SRAM controller shared by the LSU (port 0) and IFU (port 1),
// with byte-masked writes, range checking and a fixed-latency response pipe.
module cirno9_sram_ctrl
  import cirno9_mem_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int DEPTH    = 4096,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p0_req_val,
  output logic            p0_req_rdy,
  input  logic [DW/8-1:0] p0_req_wen,
  input  logic [AW-1:0]   p0_req_adr,
  input  logic [DW-1:0]   p0_req_wdat,
  output logic            p0_rsp_val,
  output logic [DW-1:0]   p0_rsp_rdat,
  output logic            p0_rsp_err,
  input  logic            p1_req_val,
  output logic            p1_req_rdy,
  input  logic [DW/8-1:0] p1_req_wen,
  input  logic [AW-1:0]   p1_req_adr,
  input  logic [DW-1:0]   p1_req_wdat,
  output logic            p1_rsp_val,
  output logic [DW-1:0]   p1_rsp_rdat,
  output logic            p1_rsp_err
);

  localparam int            NB      = DW / 8;
  localparam int            OFF_W   = log2_f(NB);
  localparam int            IDX_W   = log2_f(DEPTH);
  localparam logic [AW-1:0] HI_MASK = {AW{1'b1}} << (OFF_W + IDX_W);
  localparam logic          ARB_SEL = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  logic [DW-1:0]    mem_r [DEPTH];

  logic [1:0]       gnt_s;
  logic             acc_val_s;
  logic             acc_port_s;
  logic [NB-1:0]    acc_wen_s;
  logic [AW-1:0]    acc_adr_s;
  logic [DW-1:0]    acc_wdat_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic             acc_oor_s;
  logic             mem_we_s;
  logic             mem_re_s;

  logic             s1_val_r;
  logic             s1_port_r;
  logic             s1_err_r;
  logic [DW-1:0]    s1_rdat_r;

  logic             out_val_s;
  logic             out_port_s;
  logic             out_err_s;
  logic [DW-1:0]    out_rdat_s;

  // Requests are masked during reset so req_rdy stays low.
  cirno9_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (ARB_SEL),
    .req   ({p1_req_val, p0_req_val} & {2{rst_n}}),
    .gnt   (gnt_s)
  );

  assign p0_req_rdy = gnt_s[0];
  assign p1_req_rdy = gnt_s[1];

  // Select the granted request and classify it.
  always_comb begin
    acc_val_s  = |gnt_s;
    acc_port_s = gnt_s[1];
    if (gnt_s[1]) begin
      acc_wen_s  = p1_req_wen;
      acc_adr_s  = p1_req_adr;
      acc_wdat_s = p1_req_wdat;
    end else begin
      acc_wen_s  = p0_req_wen;
      acc_adr_s  = p0_req_adr;
      acc_wdat_s = p0_req_wdat;
    end
    acc_idx_s = acc_adr_s[OFF_W +: IDX_W];
    acc_oor_s = |(acc_adr_s & HI_MASK);
    mem_we_s  = acc_val_s && (|acc_wen_s) && !acc_oor_s;
    mem_re_s  = acc_val_s && !(|acc_wen_s) && !acc_oor_s;
  end

  // Byte-lane writes; out-of-range requests never touch the array.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_wen_s[i]) begin
          mem_r[acc_idx_s][i*8 +: 8] <= acc_wdat_s[i*8 +: 8];
        end
      end
    end
  end

  // First pipe stage: array read plus response tag; writes and errors carry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val_r  <= 1'b0;
      s1_port_r <= 1'b0;
      s1_err_r  <= 1'b0;
      s1_rdat_r <= {DW{1'b0}};
    end else begin
      s1_val_r  <= acc_val_s;
      s1_port_r <= acc_port_s;
      s1_err_r  <= acc_val_s && acc_oor_s;
      s1_rdat_r <= mem_re_s ? mem_r[acc_idx_s] : {DW{1'b0}};
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          s2_val_r;
    logic          s2_port_r;
    logic          s2_err_r;
    logic [DW-1:0] s2_rdat_r;

    // Extra register after the array for the two-cycle latency build.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_val_r  <= 1'b0;
        s2_port_r <= 1'b0;
        s2_err_r  <= 1'b0;
        s2_rdat_r <= {DW{1'b0}};
      end else begin
        s2_val_r  <= s1_val_r;
        s2_port_r <= s1_port_r;
        s2_err_r  <= s1_err_r;
        s2_rdat_r <= s1_rdat_r;
      end
    end

    assign out_val_s  = s2_val_r;
    assign out_port_s = s2_port_r;
    assign out_err_s  = s2_err_r;
    assign out_rdat_s = s2_rdat_r;
  end else begin : g_lat1
    assign out_val_s  = s1_val_r;
    assign out_port_s = s1_port_r;
    assign out_err_s  = s1_err_r;
    assign out_rdat_s = s1_rdat_r;
  end

  // Steer the single response to its issuing port; the other port sees zeros.
  assign p0_rsp_val  = out_val_s && (out_port_s == PORT_LSU);
  assign p1_rsp_val  = out_val_s && (out_port_s == PORT_IFU);
  assign p0_rsp_err  = p0_rsp_val && out_err_s;
  assign p1_rsp_err  = p1_rsp_val && out_err_s;
  assign p0_rsp_rdat = p0_rsp_val ? out_rdat_s : {DW{1'b0}};
  assign p1_rsp_rdat = p1_rsp_val ? out_rdat_s : {DW{1'b0}};

endmodule

// File: tb/tb_cirno9_sram_ctrl.sv
// Randomized bench for cirno9_sram_ctrl: a fixed-priority RD_LAT=1 instance and
// a round-robin RD_LAT=2 instance, each checked against a transaction model.
module tb_cirno9_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        v;
    logic [3:0]  wen;
    logic [31:0] adr;
    logic [31:0] wdat;
  } req_t;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT  = (g == 0) ? 1 : 2;
    localparam int MODE = g;
    localparam int N    = 300;

    logic        rst_n;
    logic        val  [2];
    logic        rdy  [2];
    logic [3:0]  wen  [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic        rv   [2];
    logic [31:0] rdat [2];
    logic        err  [2];
    logic        done_r;

    cirno9_sram_ctrl #(
      .DW(32), .AW(32), .DEPTH(4096), .RD_LAT(LAT), .ARB_MODE(MODE)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .p0_req_val  (val[0]),
      .p0_req_rdy  (rdy[0]),
      .p0_req_wen  (wen[0]),
      .p0_req_adr  (adr[0]),
      .p0_req_wdat (wdat[0]),
      .p0_rsp_val  (rv[0]),
      .p0_rsp_rdat (rdat[0]),
      .p0_rsp_err  (err[0]),
      .p1_req_val  (val[1]),
      .p1_req_rdy  (rdy[1]),
      .p1_req_wen  (wen[1]),
      .p1_req_adr  (adr[1]),
      .p1_req_wdat (wdat[1]),
      .p1_rsp_val  (rv[1]),
      .p1_rsp_rdat (rdat[1]),
      .p1_rsp_err  (err[1])
    );

    // Reference model: word store with per-byte known flags, expected-response slots.
    logic [31:0] mem_m [int];
    logic [3:0]  kn_m  [int];
    logic        ev [2][8];
    logic        ee [2][8];
    logic [31:0] ed [2][8];
    logic [31:0] em [2][8];
    logic        held [2];
    logic        last_m;
    req_t        q0 [$];
    req_t        q1 [$];

    function automatic req_t mk(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      req_t r;
      r.v = 1'b1; r.wen = w; r.adr = a; r.wdat = d;
      return r;
    endfunction

    function automatic req_t rnd_req();
      req_t r;
      r.v    = ($urandom_range(0, 3) != 0);
      r.wen  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      r.adr  = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) r.adr[$urandom_range(14, 31)] = 1'b1;
      r.wdat = $urandom;
      return r;
    endfunction

    task automatic chk_quiet(input string ph);
      for (int pp = 0; pp < 2; pp++) begin
        chk($sformatf("i%0d %s p%0d rsp_val", g, ph, pp), 32'(rv[pp]), 32'd0);
        chk($sformatf("i%0d %s p%0d rsp_rdat", g, ph, pp), rdat[pp], 32'd0);
        chk($sformatf("i%0d %s p%0d rsp_err", g, ph, pp), 32'(err[pp]), 32'd0);
      end
    endtask

    initial begin
      req_t        r;
      logic        g0, g1, oor;
      int          p, slot, idx;
      logic [31:0] m32;
      logic [3:0]  k4;
      done_r = 1'b0;
      rst_n  = 1'b0;
      last_m = 1'b1;
      for (int i = 0; i < 2; i++) begin
        held[i] = 1'b0; val[i] = 1'b1; wen[i] = 4'h0; adr[i] = 32'h0; wdat[i] = 32'h0;
        for (int j = 0; j < 8; j++) begin
          ev[i][j] = 1'b0; ee[i][j] = 1'b0; ed[i][j] = 32'h0; em[i][j] = 32'h0;
        end
      end
      q0.push_back(mk(4'hF, 32'h10,   32'hDEADBEEF));
      q0.push_back(mk(4'h0, 32'h10,   32'h0));
      q0.push_back(mk(4'hF, 32'h20,   32'h11223344));
      q0.push_back(mk(4'h5, 32'h20,   32'hAABBCCDD));
      q0.push_back(mk(4'h0, 32'h20,   32'h0));
      q0.push_back(mk(4'hF, 32'h0,    32'h0BADF00D));
      q0.push_back(mk(4'h0, 32'h4000, 32'h0));
      q0.push_back(mk(4'hF, 32'h4000, 32'hFFFFFFFF));
      q0.push_back(mk(4'h0, 32'h0,    32'h0));
      q1.push_back(mk(4'h0, 32'h10,   32'h0));
      q1.push_back(mk(4'h0, 32'h20,   32'h0));
      q1.push_back(mk(4'h0, 32'h14,   32'h0));
      q1.push_back(mk(4'h0, 32'h4,    32'h0));

      // Held in reset with both ports requesting: nothing accepted, outputs zero.
      repeat (2) begin
        @(negedge clk);
        chk_quiet("rst");
        chk($sformatf("i%0d rst rdy0", g), 32'(rdy[0]), 32'd0);
        chk($sformatf("i%0d rst rdy1", g), 32'(rdy[1]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      val[0] = 1'b0;
      val[1] = 1'b0;

      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        for (int pp = 0; pp < 2; pp++) begin
          chk($sformatf("i%0d k%0d p%0d rsp_val", g, k, pp), 32'(rv[pp]), 32'(ev[pp][k%8]));
          if (ev[pp][k%8]) begin
            chk($sformatf("i%0d k%0d p%0d rsp_err", g, k, pp), 32'(err[pp]), 32'(ee[pp][k%8]));
            if (em[pp][k%8] != 32'h0)
              chk($sformatf("i%0d k%0d p%0d rsp_rdat", g, k, pp),
                  rdat[pp] & em[pp][k%8], ed[pp][k%8] & em[pp][k%8]);
          end
          ev[pp][k%8] = 1'b0;
        end
        for (int pp = 0; pp < 2; pp++) begin
          if (!held[pp]) begin
            if (k >= N - 8) r = '0;
            else if (pp == 0 && q0.size() > 0) r = q0.pop_front();
            else if (pp == 1 && q1.size() > 0) r = q1.pop_front();
            else r = rnd_req();
            val[pp] = r.v; wen[pp] = r.wen; adr[pp] = r.adr; wdat[pp] = r.wdat;
          end
        end
        #1;
        if (val[0] && val[1]) begin
          if (MODE == 1) begin
            g0 = (last_m == 1'b1);
            g1 = !g0;
          end else begin
            g0 = 1'b1;
            g1 = 1'b0;
          end
        end else begin
          g0 = val[0];
          g1 = val[1];
        end
        chk($sformatf("i%0d k%0d rdy0", g, k), 32'(rdy[0]), 32'(g0));
        chk($sformatf("i%0d k%0d rdy1", g, k), 32'(rdy[1]), 32'(g1));
        held[0] = val[0] && !g0;
        held[1] = val[1] && !g1;
        if (g0 || g1) begin
          p      = g1 ? 1 : 0;
          last_m = g1;
          slot   = (k + LAT) % 8;
          idx    = int'(adr[p][13:2]);
          oor    = (adr[p][31:14] != 18'd0);
          if (!mem_m.exists(idx)) begin
            mem_m[idx] = 32'h0;
            kn_m[idx]  = 4'h0;
          end
          ev[p][slot] = 1'b1;
          ee[p][slot] = oor;
          ed[p][slot] = 32'h0;
          em[p][slot] = 32'hFFFFFFFF;
          if (!oor && wen[p] != 4'h0) begin
            m32 = mem_m[idx];
            k4  = kn_m[idx];
            for (int b = 0; b < 4; b++) begin
              if (wen[p][b]) begin
                m32[b*8 +: 8] = wdat[p][b*8 +: 8];
                k4[b] = 1'b1;
              end
            end
            mem_m[idx] = m32;
            kn_m[idx]  = k4;
          end else if (!oor) begin
            k4 = kn_m[idx];
            ed[p][slot] = mem_m[idx];
            em[p][slot] = {{8{k4[3]}}, {8{k4[2]}}, {8{k4[1]}}, {8{k4[0]}}};
          end
        end
      end

      // Reset right after a read is accepted: its response must never appear.
      @(negedge clk);
      val[0] = 1'b1; wen[0] = 4'h0; adr[0] = 32'h10; val[1] = 1'b0;
      #1;
      chk($sformatf("i%0d mid rdy0", g), 32'(rdy[0]), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk_quiet("mid");
        chk($sformatf("i%0d mid held rdy0", g), 32'(rdy[0]), 32'd0);
      end
      val[0] = 1'b0;
      rst_n  = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk_quiet("post");
      end
      done_r = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      if (g_inst[0].done_r === 1'b1 && g_inst[1].done_r === 1'b1) break;
      @(negedge clk);
    end
    if (!(g_inst[0].done_r === 1'b1 && g_inst[1].done_r === 1'b1))
      chk("timeout", 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
